// File: rtl/ntt_output_bitrev_reorder.sv
// Output-side reorder for an NTT frame: takes a frame in bit-reversed stream order
// and replays it in natural index order, using two ping-pong frame banks.
module ntt_output_bitrev_reorder #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 64,
    parameter int N                    = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_start,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] in_data,
    output logic                                          out_start,
    output logic                                          out_valid,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data
);

    localparam int W     = DATA_WIDTH_PER_INPUT;
    localparam int P     = INPUT_PER_CYCLE;
    localparam int BEATS = N / P;
    localparam int LOGN  = $clog2(N);
    localparam int LOGP  = $clog2(P);
    localparam int CW    = $clog2(BEATS);

    typedef enum logic { WR_IDLE = 1'b0, WR_FILL = 1'b1 } wr_state_t;
    typedef enum logic { RD_IDLE = 1'b0, RD_DRAIN = 1'b1 } rd_state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        r = {LOGN{1'b0}};
        for (int b = 0; b < LOGN; b++) begin
            r[LOGN-1-b] = x[b];
        end
        return r;
    endfunction

    wr_state_t         wr_state_r;
    logic [CW-1:0]     wr_cnt_r;
    logic              wr_bank_r;
    rd_state_t         rd_state_r;
    logic [CW-1:0]     rd_cnt_r;
    logic              rd_bank_r;
    logic              out_start_r;
    logic              out_valid_r;
    logic [P*W-1:0]    out_data_r;

    logic              wr_en_s;
    logic              wr_last_s;
    logic [CW-1:0]     wr_beat_s;
    logic [P*W-1:0]    rd_data_s;

    // Frame banks indexed by stream position; contents are never cleared.
    logic [W-1:0]      mem_r [0:1][0:N-1];

    // Decode which beat (if any) is written this cycle and whether it closes the frame.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_last_s = 1'b0;
        wr_beat_s = {CW{1'b0}};
        if (rst) begin
            wr_en_s = 1'b0;
        end else if (in_start) begin
            wr_en_s = 1'b1;
        end else if (wr_state_r == WR_FILL) begin
            wr_en_s   = 1'b1;
            wr_beat_s = wr_cnt_r;
            wr_last_s = (wr_cnt_r == CW'(BEATS - 1));
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Write-side framing: a new in_start always restarts at beat 0 in the current bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= WR_IDLE;
            wr_cnt_r   <= {CW{1'b0}};
            wr_bank_r  <= 1'b0;
        end else if (in_start) begin
            wr_state_r <= WR_FILL;
            wr_cnt_r   <= CW'(1'b1);
        end else if (wr_state_r == WR_FILL) begin
            if (wr_last_s) begin
                wr_state_r <= WR_IDLE;
                wr_cnt_r   <= {CW{1'b0}};
                wr_bank_r  <= ~wr_bank_r;
            end else begin
                wr_cnt_r   <= wr_cnt_r + CW'(1'b1);
            end
        end
    end

    // Store the incoming beat at its stream positions.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int l = 0; l < P; l++) begin
                mem_r[wr_bank_r][{wr_beat_s, LOGP'(l)}] <= in_data[l*W +: W];
            end
        end
    end

    // Natural index k*P+j lives at stream position bitrev(k*P+j).
    always_comb begin
        rd_data_s = {(P*W){1'b0}};
        for (int j = 0; j < P; j++) begin
            rd_data_s[j*W +: W] = mem_r[rd_bank_r][bitrev({rd_cnt_r, LOGP'(j)})];
        end
    end

    // Drain sequencing and registered outputs; arming on the last write beat
    // takes precedence so back-to-back drains run without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r  <= RD_IDLE;
            rd_cnt_r    <= {CW{1'b0}};
            rd_bank_r   <= 1'b0;
            out_start_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {(P*W){1'b0}};
        end else begin
            if (rd_state_r == RD_DRAIN) begin
                out_valid_r <= 1'b1;
                out_start_r <= (rd_cnt_r == {CW{1'b0}});
                out_data_r  <= rd_data_s;
                if (rd_cnt_r == CW'(BEATS - 1)) begin
                    rd_state_r <= RD_IDLE;
                    rd_cnt_r   <= {CW{1'b0}};
                end else begin
                    rd_cnt_r   <= rd_cnt_r + CW'(1'b1);
                end
            end else begin
                out_valid_r <= 1'b0;
                out_start_r <= 1'b0;
                out_data_r  <= {(P*W){1'b0}};
            end
            if (wr_last_s) begin
                rd_state_r <= RD_DRAIN;
                rd_cnt_r   <= {CW{1'b0}};
                rd_bank_r  <= wr_bank_r;
            end
        end
    end

    assign out_start = out_start_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_ntt_output_bitrev_reorder.sv
// Scoreboard bench for ntt_output_bitrev_reorder: frames are described in natural
// order, streamed bit-reversed, and expected back in natural order at fixed latency.
module tb_ntt_output_bitrev_reorder;

    localparam int W     = 28;
    localparam int P     = 64;
    localparam int N     = 1024;
    localparam int BEATS = N / P;
    localparam int LOGN  = 10;
    localparam int LAT   = BEATS + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_start;
    logic [P*W-1:0] in_data;
    logic           out_start;
    logic           out_valid;
    logic [P*W-1:0] out_data;

    ntt_output_bitrev_reorder #(
        .DATA_WIDTH_PER_INPUT(W),
        .INPUT_PER_CYCLE(P),
        .N(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_start(in_start),
        .in_data(in_data),
        .out_start(out_start),
        .out_valid(out_valid),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [P*W-1:0] data;
        bit             start;
        int             cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] nat [N];

    function automatic int bitrev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < LOGN; b++) begin
            if (x[b]) r = r | (1 << (LOGN - 1 - b));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: random, 1: natural index + base, 2: all-ones except index N-1 = 1
    task automatic fill_nat(input int kind, input int base);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       nat[i] = W'($urandom);
                1:       nat[i] = W'(base + i);
                default: nat[i] = (i == N - 1) ? 28'h0000001 : 28'hFFFFFFF;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            in_start = 1'b0;
            for (int l = 0; l < P; l++) in_data[l*W +: W] = W'($urandom);
        end
    endtask

    // Stream nbeats of the current frame; a complete frame queues its natural-order image.
    task automatic drive_frame(input int nbeats);
        int   t0;
        exp_t e;
        t0 = 0;
        for (int c = 0; c < nbeats; c++) begin
            step();
            in_start = (c == 0);
            for (int l = 0; l < P; l++) in_data[l*W +: W] = nat[bitrev(c*P + l)];
            if (c == 0) t0 = cyc;
        end
        if (nbeats == BEATS) begin
            for (int k = 0; k < BEATS; k++) begin
                for (int j = 0; j < P; j++) e.data[j*W +: W] = nat[k*P + j];
                e.start = (k == 0);
                e.cyc   = t0 + LAT + k;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_reset();
        int tr;
        step();
        rst      = 1'b1;
        in_start = 1'b0;
        tr       = cyc;
        while (sb_q.size() > 0 && sb_q[$].cyc > tr) void'(sb_q.pop_back());
        step();
        rst = 1'b0;
    endtask

    // Monitor: every cycle the output must match exactly the entry due this cycle, or be idle zeros.
    always @(negedge clk) begin
        exp_t           e;
        logic [P*W-1:0] ed;
        bit             ev;
        bit             es;
        int             bad;
        if (mon_en) begin
            ev = 1'b0;
            es = 1'b0;
            ed = '0;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missed_beat: due cyc %0d, still pending at cyc %0d", e.cyc, cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e  = sb_q.pop_front();
                ev = 1'b1;
                es = e.start;
                ed = e.data;
            end
            n_cmp++;
            if (out_valid !== ev || out_start !== es || out_data !== ed) begin
                n_err++;
                bad = 0;
                for (int j = P - 1; j >= 0; j--) begin
                    if (out_data[j*W +: W] !== ed[j*W +: W]) bad = j;
                end
                $display("FAIL out_beat cyc %0d: valid %b want %b, start %b want %b, lane %0d data %h want %h",
                         cyc, out_valid, ev, out_start, es, bad, out_data[bad*W +: W], ed[bad*W +: W]);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_start = 1'b0;
        in_data  = '0;
        repeat (3) step();
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(5);

        // single frame, values = natural index
        fill_nat(1, 0);
        drive_frame(BEATS);
        idle(25);

        // three back-to-back frames with per-frame offsets
        for (int f = 0; f < 3; f++) begin
            fill_nat(1, f * 4096);
            drive_frame(BEATS);
        end
        idle(20);

        // restart mid-fill: only the second frame comes out
        fill_nat(1, 0);
        drive_frame(7);
        fill_nat(1, 100);
        drive_frame(BEATS);
        idle(20);

        // reset while draining, then a fresh frame
        fill_nat(0, 0);
        drive_frame(BEATS);
        idle(5);
        pulse_reset();
        idle(4);
        fill_nat(0, 0);
        drive_frame(BEATS);
        idle(20);

        // long idle gap between frames
        fill_nat(0, 0);
        drive_frame(BEATS);
        idle(34);
        fill_nat(0, 0);
        drive_frame(BEATS);
        idle(20);

        // full-width lane pattern
        fill_nat(2, 0);
        drive_frame(BEATS);
        idle(20);

        // randomized frames with random gaps and occasional aborted fills
        for (int r = 0; r < 8; r++) begin
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                fill_nat(0, 0);
                drive_frame($urandom_range(1, BEATS - 1));
            end
            fill_nat(0, 0);
            drive_frame(BEATS);
        end
        idle(30);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d beats outstanding, want 0", sb_q.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
